cobs_frame_decoder: RTL and testbench

// - Host-facing end of the UART trace path: COBS-decodes the 0x00-delimited byte stream

---
 rtl/cobs_frame_decoder.sv | 247 ++++++++++++++++++++++++
 tb/tb_cobs_frame_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cobs_frame_decoder.sv
// cobs_frame_decoder
//   COBS-decodes the 0x00-delimited UART trace byte stream back into frame
//   payload bytes, with per-frame status.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   in_data/in_valid     encoded input byte stream
//   in_ready             combinational: !out_valid || out_ready
//   out_data/out_valid   decoded payload byte, accepted on out_ready
//   out_last             out_data is the final byte of its frame
//   frame_done           1-cycle pulse at frame termination
//   frame_len            decoded bytes delivered for the frame (with frame_done)
//   frame_error          frame truncated or overflowed (with frame_done)
// Optional feature (macro COBS_DEC_STATS_EN):
//   stat_frames/stat_errors/stat_dropped saturating 16-bit counters.
module cobs_frame_decoder #(
  parameter int unsigned MaxFrameLen = 256,
  parameter int unsigned LenWidth    = $clog2(MaxFrameLen + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                frame_done,
  output logic [LenWidth-1:0] frame_len,
  output logic                frame_error
`ifdef COBS_DEC_STATS_EN
  ,
  output logic [15:0]         stat_frames,
  output logic [15:0]         stat_errors,
  output logic [15:0]         stat_dropped
`endif
);

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    CODE   = 2'd1,
    DATA   = 2'd2,
    DROP   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            remaining_q, remaining_d;
  logic                  pend_zero_q, pend_zero_d;
  logic                  in_frame_q, in_frame_d;
  logic [7:0]            hold_data_q, hold_data_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  frame_done_q, frame_done_d;
  logic [LenWidth-1:0]   frame_len_q, frame_len_d;
  logic                  frame_error_q, frame_error_d;

  logic                  accept;
  logic                  produce;
  logic [7:0]            prod_byte;
  logic                  terminate;
  logic                  term_err;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state: decode FSM, hold-register delivery, overflow and termination
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    pend_zero_d   = pend_zero_q;
    in_frame_d    = in_frame_q;
    hold_data_d   = hold_data_q;
    hold_valid_d  = hold_valid_q;
    len_d         = len_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_last_d    = out_last_q;
    frame_done_d  = 1'b0;
    frame_len_d   = frame_len_q;
    frame_error_d = frame_error_q;
    produce       = 1'b0;
    prod_byte     = 8'h00;
    terminate     = 1'b0;
    term_err      = 1'b0;

    if (accept) begin
      unique case (state_q)
        RESYNC: begin
          if (in_data == 8'h00) state_d = CODE;
        end
        CODE: begin
          if (in_data == 8'h00) begin
            // Delimiter with no code byte seen is just an inter-frame gap
            terminate = in_frame_q;
          end else begin
            in_frame_d  = 1'b1;
            remaining_d = in_data - 8'd1;
            produce     = pend_zero_q;
            prod_byte   = 8'h00;
            pend_zero_d = (in_data != 8'hFF);
            state_d     = (in_data > 8'd1) ? DATA : CODE;
          end
        end
        DATA: begin
          if (in_data == 8'h00) begin
            terminate = 1'b1;
            term_err  = 1'b1;
          end else begin
            produce     = 1'b1;
            prod_byte   = in_data;
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_d = CODE;
          end
        end
        DROP: begin
          if (in_data == 8'h00) begin
            terminate = 1'b1;
            term_err  = 1'b1;
          end
        end
        default: state_d = RESYNC;
      endcase
    end

    if (produce) begin
      if (len_q == LenWidth'(MaxFrameLen)) begin
        // Overflow: drop this byte, flush hold as the frame's last byte
        state_d      = DROP;
        hold_valid_d = 1'b0;
        if (hold_valid_q) begin
          out_data_d  = hold_data_q;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end
      end else begin
        hold_data_d  = prod_byte;
        hold_valid_d = 1'b1;
        len_d        = len_q + LenWidth'(1);
        if (hold_valid_q) begin
          out_data_d  = hold_data_q;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end
    end

    if (terminate) begin
      if (hold_valid_q) begin
        out_data_d  = hold_data_q;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
      end
      hold_valid_d  = 1'b0;
      frame_done_d  = 1'b1;
      frame_len_d   = len_q;
      frame_error_d = term_err;
      len_d         = '0;
      pend_zero_d   = 1'b0;
      in_frame_d    = 1'b0;
      state_d       = CODE;
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= RESYNC;
      remaining_q   <= 8'h00;
      pend_zero_q   <= 1'b0;
      in_frame_q    <= 1'b0;
      hold_data_q   <= 8'h00;
      hold_valid_q  <= 1'b0;
      len_q         <= '0;
      out_data_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_len_q   <= '0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      pend_zero_q   <= pend_zero_d;
      in_frame_q    <= in_frame_d;
      hold_data_q   <= hold_data_d;
      hold_valid_q  <= hold_valid_d;
      len_q         <= len_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_done_q  <= frame_done_d;
      frame_len_q   <= frame_len_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign frame_done  = frame_done_q;
  assign frame_len   = frame_len_q;
  assign frame_error = frame_error_q;

`ifdef COBS_DEC_STATS_EN
  logic [15:0] stat_frames_q, stat_frames_d;
  logic [15:0] stat_errors_q, stat_errors_d;
  logic [15:0] stat_dropped_q, stat_dropped_d;
  logic        drop_byte;

  // Non-delimiter bytes discarded while hunting for a frame boundary
  assign drop_byte = accept && (in_data != 8'h00) &&
                     ((state_q == RESYNC) || (state_q == DROP));

  // Saturating statistics counters
  always_comb begin
    stat_frames_d  = stat_frames_q;
    stat_errors_d  = stat_errors_q;
    stat_dropped_d = stat_dropped_q;
    if (frame_done_d && (stat_frames_q != 16'hFFFF))
      stat_frames_d = stat_frames_q + 16'd1;
    if (frame_done_d && term_err && (stat_errors_q != 16'hFFFF))
      stat_errors_d = stat_errors_q + 16'd1;
    if (drop_byte && (stat_dropped_q != 16'hFFFF))
      stat_dropped_d = stat_dropped_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_frames_q  <= 16'h0000;
      stat_errors_q  <= 16'h0000;
      stat_dropped_q <= 16'h0000;
    end else begin
      stat_frames_q  <= stat_frames_d;
      stat_errors_q  <= stat_errors_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_frames  = stat_frames_q;
  assign stat_errors  = stat_errors_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_cobs_frame_decoder.sv
// tb_cobs_frame_decoder
//   Directed-vector bench for cobs_frame_decoder: drives encoded streams,
//   collects decoded bytes and frame status, compares against hand-computed
//   expectations.
module tb_cobs_frame_decoder;

  localparam int unsigned MaxLen = 256;
  localparam int unsigned LW     = $clog2(MaxLen + 1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          frame_done;
  logic [LW-1:0] frame_len;
  logic          frame_error;
`ifdef COBS_DEC_STATS_EN
  logic [15:0]   stat_frames, stat_errors, stat_dropped;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] obs_bytes[$];
  logic [31:0] exp_bytes[$];
  logic [31:0] obs_frames[$];
  logic [31:0] exp_frames[$];

  cobs_frame_decoder #(.MaxFrameLen(MaxLen)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .frame_error (frame_error)
`ifdef COBS_DEC_STATS_EN
    ,
    .stat_frames (stat_frames),
    .stat_errors (stat_errors),
    .stat_dropped(stat_dropped)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Inputs change at posedge+1, so negedge sees what the next posedge will use
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (out_valid && out_ready) obs_bytes.push_back(32'({out_last, out_data}));
      if (frame_done) obs_frames.push_back(32'({frame_error, frame_len}));
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic last);
    exp_bytes.push_back(32'({last, d}));
  endtask

  task automatic exp_frame(input int unsigned len, input logic err);
    exp_frames.push_back(32'({err, LW'(len)}));
  endtask

  // Present one byte and hold it until accepted; call at posedge+1
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk_i);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk_eq("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic check_sb(input string tag);
    repeat (4) @(posedge clk_i);
    #1;
    chk_eq({tag, "_nbytes"}, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++)
      if (i < obs_bytes.size()) chk_eq({tag, "_byte"}, obs_bytes[i], exp_bytes[i]);
    chk_eq({tag, "_nframes"}, 32'(obs_frames.size()), 32'(exp_frames.size()));
    for (int i = 0; i < exp_frames.size(); i++)
      if (i < obs_frames.size()) chk_eq({tag, "_frame"}, obs_frames[i], exp_frames[i]);
    obs_bytes.delete();
    exp_bytes.delete();
    obs_frames.delete();
    exp_frames.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s[$];

    do_reset();
    chk_eq("rst_out_valid",   32'(out_valid),   32'd0);
    chk_eq("rst_in_ready",    32'(in_ready),    32'd1);
    chk_eq("rst_out_last",    32'(out_last),    32'd0);
    chk_eq("rst_out_data",    32'(out_data),    32'd0);
    chk_eq("rst_frame_done",  32'(frame_done),  32'd0);
    chk_eq("rst_frame_len",   32'(frame_len),   32'd0);
    chk_eq("rst_frame_error", 32'(frame_error), 32'd0);

    // Basic frame with an embedded zero
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    send_q(s);
    exp_byte(8'h11, 0); exp_byte(8'h22, 0); exp_byte(8'h00, 0); exp_byte(8'h33, 1);
    exp_frame(4, 0);
    check_sb("basic");

    // Single zero payload, then empty frame, with a gap delimiter
    s = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    send_q(s);
    exp_byte(8'h00, 1);
    exp_frame(1, 0);
    exp_frame(0, 0);
    check_sb("zeros");

    // Full 0xFF block: no implicit zero after it
    send(8'h00);
    send(8'hFF);
    for (int i = 0; i < 254; i++) begin
      send(8'hAA);
      exp_byte(8'hAA, 0);
    end
    s = '{8'h02, 8'hBB, 8'h00};
    send_q(s);
    exp_byte(8'hBB, 1);
    exp_frame(255, 0);
    check_sb("ff_block");

    // Truncated frame, then a clean frame
    s = '{8'h00, 8'h04, 8'h11, 8'h00, 8'h03, 8'h55, 8'h66, 8'h00};
    send_q(s);
    exp_byte(8'h11, 1);
    exp_frame(1, 1);
    exp_byte(8'h55, 0); exp_byte(8'h66, 1);
    exp_frame(2, 0);
    check_sb("trunc");

    // Output stall for 10 cycles mid-frame
    s = '{8'h00, 8'h06, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00};
    fork
      send_q(s);
      begin
        repeat (3) @(posedge clk_i);
        #1 out_ready = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        chk_eq("stall_in_ready",  32'(in_ready),  32'd0);
        chk_eq("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk_i);
        #1 out_ready = 1'b1;
      end
    join
    exp_byte(8'hA1, 0); exp_byte(8'hA2, 0); exp_byte(8'hA3, 0);
    exp_byte(8'hA4, 0); exp_byte(8'hA5, 1);
    exp_frame(5, 0);
    check_sb("stall");

    // Reset mid-frame discards it; garbage before the next delimiter is dropped
    s = '{8'h00, 8'h04, 8'h11};
    send_q(s);
    do_reset();
    s = '{8'h05, 8'h11, 8'h00, 8'h02, 8'h77, 8'h00};
    send_q(s);
    exp_byte(8'h77, 1);
    exp_frame(1, 0);
    check_sb("resync");
`ifdef COBS_DEC_STATS_EN
    chk_eq("stat_dropped", 32'(stat_dropped), 32'd2);
    chk_eq("stat_frames",  32'(stat_frames),  32'd1);
    chk_eq("stat_errors",  32'(stat_errors),  32'd0);
`endif

    // Overflow: 257 payload bytes -> 256 delivered, last on the 256th
    send(8'h00);
    send(8'hFF);
    for (int i = 0; i < 254; i++) begin
      logic [7:0] d;
      d = 8'((i % 250) + 1);
      send(d);
      exp_byte(d, 0);
    end
    s = '{8'h04, 8'hB1, 8'hB2, 8'hB3, 8'h00, 8'h02, 8'h77, 8'h00};
    send_q(s);
    exp_byte(8'hB1, 0); exp_byte(8'hB2, 1);
    exp_frame(MaxLen, 1);
    exp_byte(8'h77, 1);
    exp_frame(1, 0);
    check_sb("overflow");
`ifdef COBS_DEC_STATS_EN
    chk_eq("stat_errors_ovf", 32'(stat_errors), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
